mem_responder: RTL



---
 rtl/mem_responder.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Fixed-latency backing-memory responder for the cache mem_* handshake, built on a word-wide RAM.
// Optional request counters rd_count/wr_count are enabled by defining MEM_RESPONDER_STATS_EN.
module mem_responder #(
  parameter int AddrBusWidth = 32,
  parameter int MemBusWidth  = 64,
  parameter int Depth        = 1024,
  parameter int Latency      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddrBusWidth-1:0] mem_addr,
  input  logic [MemBusWidth-1:0]  mem_w_data,
  input  logic                    mem_re,
  input  logic                    mem_we,
  output logic [MemBusWidth-1:0]  mem_r_data,
  output logic                    mem_busy,
  output logic                    mem_done
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count
`endif
);

  localparam int OB = $clog2(MemBusWidth / 8);
  localparam int IW = $clog2(Depth);
  localparam logic [7:0] LatM1 = 8'(Latency - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic                   op_rd;
  logic                   accept;
  logic [IW-1:0]          idx;
  logic [MemBusWidth-1:0] rd_q;
  logic [MemBusWidth-1:0] ram [Depth];
  logic                   unused_addr;

  // Only the word-index bits take part; offset and alias bits are dropped.
  assign idx         = mem_addr[OB +: IW];
  assign unused_addr = ^mem_addr;
  assign accept      = rst_n && (state == IDLE) && (mem_re || mem_we);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_busy  = 1'b0;
    mem_done  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_re || mem_we) begin
          state_nxt = BUSY;
          cnt_nxt   = LatM1;
        end
      end
      BUSY: begin
        mem_busy = 1'b1;
        if (cnt == 8'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      DONE: begin
        mem_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      op_rd      <= 1'b0;
      mem_r_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) op_rd <= mem_re;
      // Publish the captured word as the FSM enters DONE, so it is valid with mem_done.
      if (state == BUSY && cnt == 8'd0 && op_rd) mem_r_data <= rd_q;
    end
  end

  // RAM is not reset; nonblocking order gives read-before-write on combined requests.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (mem_re) rd_q <= ram[idx];
      if (mem_we) ram[idx] <= mem_w_data;
    end
  end

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else if (accept) begin
      if (mem_re) rd_count <= rd_count + 32'd1;
      if (mem_we) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule
